tcdm_bank_ctrl: RTL
===================

Name: tcdm_bank_ctrl

Overview:
Initiator-side controller for one single-port TCDM SRAM bank. It converts the cluster-side TCDM request/grant/r_valid protocol into the bank's active-low macro pins: CSN, WEN, WMN bit mask, A, D, Q, INITN and STDBY. It also sequences macro power states: init after reset, standby on request or idle timeout, and wake-up latency. One instance sits in front of each bank in the TCDM interconnect.

Parameters:
ADDR_WIDTH, 10, bank word-address width (1024 words)
DATA_WIDTH, 32, data width; must be a multiple of 8
BE_WIDTH, DATA_WIDTH/8, byte-enable width
INIT_CYCLES, 4, cycles INITN held low after reset release (>=1)
WAKE_CYCLES, 2, cycles after STDBY falls before grant is allowed (>=1)
IDLE_SLEEP_CYCLES, 0, idle cycles before automatic standby; 0 disables auto-sleep

Ports:
CLK  in  1  clock
RSTN  in  1  reset, synchronous, active-low
tcdm_req_i  in  1  request
tcdm_gnt_o  out  1  grant
tcdm_add_i  in  ADDR_WIDTH  word address
tcdm_wen_i  in  1  1=read, 0=write
tcdm_be_i  in  BE_WIDTH  byte enables
tcdm_wdata_i  in  DATA_WIDTH  write data
tcdm_r_valid_o  out  1  response valid
tcdm_r_rdata_o  out  DATA_WIDTH  read data
sleep_req_i  in  1  software standby request
sleep_o  out  1  bank in standby
sram_csn_o  out  1  chip select, active-low
sram_wen_o  out  1  write enable, active-low
sram_wmn_o  out  DATA_WIDTH  bit write mask, active-low
sram_a_o  out  ADDR_WIDTH  address
sram_d_o  out  DATA_WIDTH  write data
sram_q_i  in  DATA_WIDTH  read data, valid the cycle after a read access
sram_initn_o  out  1  macro init, active-low
sram_stdby_o  out  1  macro standby

Behaviour:
- Reset (RSTN=0 at an edge) forces the following: state INIT; csn=1; wen=1; wmn all 1; a=0; d=0; initn=0; stdby=0; gnt=0; r_valid=0; r_rdata hold register=0; sleep_o=0; all counters=0.
- Reset mid-operation: any in-flight response is dropped, r_valid=0 next cycle, and the INIT sequence repeats.
- FSM states: INIT, READY, SLEEP, WAKE.
- INIT: initn=0 for INIT_CYCLES cycles after reset release, then initn=1 and the FSM moves to READY. gnt=0 throughout INIT.
- READY: tcdm_gnt_o=1 combinationally when sleep_req_i=0. tcdm_gnt_o does not depend on req. An access is accepted when acc = req & gnt.
- Pin drive, combinational on acc=1: csn=0; wen=tcdm_wen_i; a=tcdm_add_i; d=tcdm_wdata_i. For a write, wmn[i] = ~be[i/8]; for a read, wmn is all 1. The macro captures on the same edge.
- Pin drive on acc=0: csn=1; wen=1; wmn all 1; a and d hold the last accepted values from shadow registers, to avoid toggling.
- Response: tcdm_r_valid_o=1 exactly one cycle after every accepted access, reads and writes alike. Sustained throughput is 1 access per cycle.
- r_rdata for a read response: r_rdata = sram_q_i in the r_valid cycle, and the hold register captures it.
- r_rdata otherwise (write response or no response): r_rdata = hold register, so it stays stable.
- Idle counter: cleared on acc. Otherwise it increments and saturates at IDLE_SLEEP_CYCLES.
- READY->SLEEP when all of the following hold in the same cycle:
  - acc=0
  - no response pending next cycle
  - sleep_req_i=1, or (IDLE_SLEEP_CYCLES!=0 and idle counter==IDLE_SLEEP_CYCLES)
- The SLEEP cause is recorded in a flag: software or auto.
- SLEEP: stdby=1; sleep_o=1; gnt=0; csn=1. Any pending req waits; the TCDM rule requires req to stay high until granted.
- SLEEP->WAKE when sleep_req_i=0 and (cause=software or req=1).
- WAKE: stdby=0; sleep_o=0; gnt=0. After WAKE_CYCLES cycles the FSM moves to READY.
- Simultaneous events:
  - sleep_req_i rising in the same cycle as a request in READY: gnt=0, so no access is accepted.
  - A request already accepted the previous cycle still gets its r_valid before SLEEP is entered.
- Width rule: wmn expansion replicates each be bit 8 times, LSB byte first.

Decomposition:
- Package tcdm_bank_ctrl_pkg holds:
  - the state enum (INIT, READY, SLEEP, WAKE)
  - the sleep-cause type
  - a function be_to_wmn(be) returning the active-low bit mask
- Sub-module tcdm_bank_pwr_fsm owns:
  - the state register, INIT/WAKE/idle counters and sleep-cause flag
  - outputs: state, initn, stdby, sleep_o, grant_allowed
- The top level owns the handshake, pin muxing, shadow registers and the r_valid/r_rdata path.

Test Plan:
- Reset release: initn=0 for 4 cycles with gnt=0, then initn=1. gnt=1 from cycle 5 onward.
- Write add=0x3A5, be=4'b0101, wdata=0xDEADBEEF: csn=0, wen=0, wmn=0xFF00FF00 in the accept cycle. r_valid=1 next cycle; r_rdata unchanged.
- Back-to-back read 0x3A5 then read 0x001: r_valid on both following cycles. r_rdata=Q each time; after the second response, r_rdata holds its value with csn=1.
- Software sleep: raise sleep_req_i; stdby=1 and sleep_o=1 next cycle, and a req stays ungranted. Drop sleep_req_i: stdby=0, then gnt=1 after 2 cycles and the pending req is accepted.
- IDLE_SLEEP_CYCLES=8: after 8 idle cycles the bank enters SLEEP. Asserting req then gives WAKE, and gnt rises 2 cycles after stdby falls.
- Assert RSTN=0 in the cycle after a read is accepted: r_valid stays 0, all pins return to reset values, and INIT repeats.

Source files
------------

// File: rtl/tcdm_bank_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// tcdm_bank_ctrl_pkg : power-state and sleep-cause types, byte-enable to
//                      active-low bit-mask expansion helper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tcdm_bank_ctrl_pkg;

  // Upper bound on DATA_WIDTH supported by be_to_wmn.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } pwr_state_e;

  typedef enum logic {
    CAUSE_SW   = 1'b0,
    CAUSE_AUTO = 1'b1
  } sleep_cause_e;

  // Each byte-enable bit covers 8 mask bits, LSB byte first; enabled byte -> 0.
  function automatic logic [MAX_DATA_WIDTH-1:0] be_to_wmn(input logic [MAX_BE_WIDTH-1:0] be);
    logic [MAX_DATA_WIDTH-1:0] wmn;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      wmn[i] = ~be[i/8];
    end
    return wmn;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tcdm_bank_ctrl_if.sv
// ----------------------------------------------------------------------------
// tcdm_bank_ctrl_if : cluster-side TCDM request/grant/response bundle.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface tcdm_bank_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) ();

  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] add;
  logic                  wen;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_rdata
  );

endinterface

`default_nettype wire

// File: rtl/tcdm_bank_pwr_fsm.sv
// ----------------------------------------------------------------------------
// tcdm_bank_pwr_fsm : macro power sequencing (init, standby, wake-up) with
//                     idle-timeout auto-sleep and registered pin outputs.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tcdm_bank_pwr_fsm
  import tcdm_bank_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES       = 4,
  parameter int WAKE_CYCLES       = 2,
  parameter int IDLE_SLEEP_CYCLES = 0
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       acc_i,
  input  logic       req_i,
  input  logic       sleep_req_i,
  output pwr_state_e state_o,
  output logic       initn_o,
  output logic       stdby_o,
  output logic       sleep_o,
  output logic       grant_allowed_o
);

  localparam int SEQ_MAX = (INIT_CYCLES > WAKE_CYCLES) ? INIT_CYCLES : WAKE_CYCLES;
  localparam int SEQ_W   = (SEQ_MAX < 2) ? 1 : $clog2(SEQ_MAX);
  localparam int IDLE_W  = (IDLE_SLEEP_CYCLES < 2) ? 1 : $clog2(IDLE_SLEEP_CYCLES + 1);

  localparam logic [SEQ_W-1:0]  INIT_LAST = SEQ_W'(INIT_CYCLES - 1);
  localparam logic [SEQ_W-1:0]  WAKE_LAST = SEQ_W'(WAKE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_SLEEP_CYCLES);

  pwr_state_e        state_q, state_d;
  sleep_cause_e      cause_q, cause_d;
  logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              initn_q, initn_d;
  logic              stdby_q, stdby_d;
  logic              sleep_q, sleep_d;
  logic              grant_allowed_q, grant_allowed_d;
  logic              auto_sleep;

  assign auto_sleep = (IDLE_SLEEP_CYCLES != 0) && (idle_cnt_q == IDLE_MAX);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    seq_cnt_d  = seq_cnt_q;
    idle_cnt_d = '0;
    case (state_q)
      ST_INIT: begin
        if (seq_cnt_q == INIT_LAST) begin
          state_d   = ST_READY;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      ST_READY: begin
        if (acc_i) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
        // With no access this cycle there is no response owed next cycle.
        if (!acc_i && (sleep_req_i || auto_sleep)) begin
          state_d    = ST_SLEEP;
          cause_d    = sleep_req_i ? CAUSE_SW : CAUSE_AUTO;
          idle_cnt_d = '0;
        end
      end
      ST_SLEEP: begin
        if (!sleep_req_i && ((cause_q == CAUSE_SW) || req_i)) begin
          state_d   = ST_WAKE;
          seq_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        if (seq_cnt_q == WAKE_LAST) begin
          state_d   = ST_READY;
          seq_cnt_d = '0;
        end else begin
          seq_cnt_d = seq_cnt_q + SEQ_W'(1);
        end
      end
      default: begin
        state_d   = ST_INIT;
        seq_cnt_d = '0;
      end
    endcase

    initn_d         = (state_d != ST_INIT);
    stdby_d         = (state_d == ST_SLEEP);
    sleep_d         = (state_d == ST_SLEEP);
    grant_allowed_d = (state_d == ST_READY);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q         <= ST_INIT;
      cause_q         <= CAUSE_SW;
      seq_cnt_q       <= '0;
      idle_cnt_q      <= '0;
      initn_q         <= 1'b0;
      stdby_q         <= 1'b0;
      sleep_q         <= 1'b0;
      grant_allowed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cause_q         <= cause_d;
      seq_cnt_q       <= seq_cnt_d;
      idle_cnt_q      <= idle_cnt_d;
      initn_q         <= initn_d;
      stdby_q         <= stdby_d;
      sleep_q         <= sleep_d;
      grant_allowed_q <= grant_allowed_d;
    end
  end

  assign state_o         = state_q;
  assign initn_o         = initn_q;
  assign stdby_o         = stdby_q;
  assign sleep_o         = sleep_q;
  assign grant_allowed_o = grant_allowed_q;

endmodule

`default_nettype wire

// File: rtl/tcdm_bank_ctrl.sv
// ----------------------------------------------------------------------------
// tcdm_bank_ctrl : TCDM req/gnt/r_valid to single-port SRAM macro pin adapter
//                  with power-state sequencing.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tcdm_bank_ctrl
  import tcdm_bank_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int BE_WIDTH          = DATA_WIDTH / 8,
  parameter int INIT_CYCLES       = 4,
  parameter int WAKE_CYCLES       = 2,
  parameter int IDLE_SLEEP_CYCLES = 0
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  tcdm_bank_ctrl_if.slave       tcdm,
  input  logic                  sleep_req_i,
  output logic                  sleep_o,
  output logic                  sram_csn_o,
  output logic                  sram_wen_o,
  output logic [DATA_WIDTH-1:0] sram_wmn_o,
  output logic [ADDR_WIDTH-1:0] sram_a_o,
  output logic [DATA_WIDTH-1:0] sram_d_o,
  input  logic [DATA_WIDTH-1:0] sram_q_i,
  output logic                  sram_initn_o,
  output logic                  sram_stdby_o
);

  pwr_state_e            pwr_state;
  logic                  grant_allowed;
  logic                  gnt;
  logic                  acc;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] rdata;

  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic                  r_valid_q, r_valid_d;
  logic                  rd_resp_q, rd_resp_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  tcdm_bank_pwr_fsm #(
    .INIT_CYCLES       (INIT_CYCLES),
    .WAKE_CYCLES       (WAKE_CYCLES),
    .IDLE_SLEEP_CYCLES (IDLE_SLEEP_CYCLES)
  ) u_pwr_fsm (
    .CLK             (CLK),
    .RSTN            (RSTN),
    .acc_i           (acc),
    .req_i           (tcdm.req),
    .sleep_req_i     (sleep_req_i),
    .state_o         (pwr_state),
    .initn_o         (sram_initn_o),
    .stdby_o         (sram_stdby_o),
    .sleep_o         (sleep_o),
    .grant_allowed_o (grant_allowed)
  );

  // Grant is independent of req; a rising sleep_req_i blocks it the same cycle.
  assign gnt = grant_allowed && (pwr_state == ST_READY) && !sleep_req_i;
  assign acc = tcdm.req && gnt;
  assign be  = tcdm.be;

  always_comb begin
    a_d       = acc ? tcdm.add   : a_q;
    d_d       = acc ? tcdm.wdata : d_q;
    r_valid_d = acc;
    rd_resp_d = acc && tcdm.wen;
    // Q is only meaningful the cycle after a read; otherwise replay the hold copy.
    rdata     = rd_resp_q ? sram_q_i : hold_q;
    hold_d    = rdata;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      a_q       <= '0;
      d_q       <= '0;
      r_valid_q <= 1'b0;
      rd_resp_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      a_q       <= a_d;
      d_q       <= d_d;
      r_valid_q <= r_valid_d;
      rd_resp_q <= rd_resp_d;
      hold_q    <= hold_d;
    end
  end

  assign sram_csn_o = !acc;
  assign sram_wen_o = acc ? tcdm.wen : 1'b1;
  assign sram_wmn_o = (acc && !tcdm.wen) ? DATA_WIDTH'(be_to_wmn(MAX_BE_WIDTH'(be)))
                                         : {DATA_WIDTH{1'b1}};
  // Address and data pins park on the last accepted values to avoid toggling.
  assign sram_a_o   = a_d;
  assign sram_d_o   = d_d;

  assign tcdm.gnt     = gnt;
  assign tcdm.r_valid = r_valid_q;
  assign tcdm.r_rdata = rdata;

endmodule

`default_nettype wire
